// File: rtl/axi_riscv_amo_perf_pkg.sv
// Shared constants and response type for the AMO performance counter bank.
package axi_riscv_amo_perf_pkg;

    localparam int DEF_NUM_CNT   = 32;
    localparam int DEF_CNT_WIDTH = 32;
    localparam int DEF_INC_WIDTH = 4;
    localparam int MAX_CNT_WIDTH = 64;

    // Read response; data is carried at the widest supported counter width.
    typedef struct packed {
        logic [MAX_CNT_WIDTH-1:0] data;
        logic                     ovf;
        logic                     err;
    } perf_rsp_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_riscv_amo_perf_cnt_slice.sv
// One counter: zero-extended add with wrap or saturate, sticky overflow,
// and clear > read-and-clear > increment priority.
module axi_riscv_amo_perf_cnt_slice #(
    parameter int CNT_WIDTH = 32,
    parameter int INC_WIDTH = 4,
    parameter int SATURATE  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INC_WIDTH-1:0] inc_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 rc_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH-1:0] inc_ext;

    assign inc_ext = CNT_WIDTH'(inc_i);
    assign sum     = {1'b0, cnt_q} + {1'b0, inc_ext};

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (rc_i) begin
            // The cycle's event is kept as the new starting value.
            cnt_d = en_i ? inc_ext : '0;
            ovf_d = 1'b0;
        end else if (en_i) begin
            if (sum[CNT_WIDTH]) begin
                cnt_d = (SATURATE != 0) ? '1 : sum[CNT_WIDTH-1:0];
                ovf_d = 1'b1;
            end else begin
                cnt_d = sum[CNT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/axi_riscv_amo_perf_bank.sv
// Bank of event counters with a single-outstanding read / read-and-clear port.
// Optional shadow snapshot bank enabled by AXI_RISCV_AMO_PERF_SNAPSHOT_EN.
module axi_riscv_amo_perf_bank
    import axi_riscv_amo_perf_pkg::*;
#(
    parameter int NUM_CNT   = DEF_NUM_CNT,
    parameter int CNT_WIDTH = DEF_CNT_WIDTH,
    parameter int INC_WIDTH = DEF_INC_WIDTH,
    parameter int SATURATE  = 0,
    localparam int IDX_WIDTH = idx_width(NUM_CNT)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
`ifdef AXI_RISCV_AMO_PERF_SNAPSHOT_EN
    input  logic                           snap_i,
`endif
    input  logic [NUM_CNT*INC_WIDTH-1:0]   evt_inc_i,
    input  logic [NUM_CNT-1:0]             cnt_en_i,
    input  logic [NUM_CNT-1:0]             cnt_clr_i,
    output logic [NUM_CNT*CNT_WIDTH-1:0]   cnt_o,
    output logic [NUM_CNT-1:0]             ovf_o,
    input  logic                           rd_req_valid_i,
    output logic                           rd_req_ready_o,
    input  logic [IDX_WIDTH-1:0]           rd_req_idx_i,
    input  logic                           rd_req_clr_i,
    output logic                           rd_rsp_valid_o,
    input  logic                           rd_rsp_ready_i,
    output logic [CNT_WIDTH-1:0]           rd_rsp_data_o,
    output logic                           rd_rsp_ovf_o,
    output logic                           rd_rsp_err_o
);

    // Handshakes: a beat transfers on a rising edge where valid && ready.
    // The response register is one deep and may be refilled in the same
    // cycle it is drained, so req_ready = !rsp_valid || rsp_ready.
    logic                 req_accept;
    logic                 idx_ok;
    logic [NUM_CNT-1:0]   rc_vec;
    logic [CNT_WIDTH-1:0] live_cnt [NUM_CNT];
    logic [CNT_WIDTH-1:0] src_cnt  [NUM_CNT];
    logic [NUM_CNT-1:0]   src_ovf;
    logic [CNT_WIDTH-1:0] sel_data;
    logic                 sel_ovf;
    perf_rsp_t            rsp_d, rsp_q;
    logic                 rsp_valid_q;
    logic                 rsp_data_unused;

    assign rd_req_ready_o = !rsp_valid_q || rd_rsp_ready_i;
    assign req_accept     = rd_req_valid_i && rd_req_ready_o;
    assign idx_ok         = ({1'b0, rd_req_idx_i} < (IDX_WIDTH+1)'(NUM_CNT));

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_slice
        assign rc_vec[i] = req_accept && rd_req_clr_i && (rd_req_idx_i == IDX_WIDTH'(i));

        axi_riscv_amo_perf_cnt_slice #(
            .CNT_WIDTH (CNT_WIDTH),
            .INC_WIDTH (INC_WIDTH),
            .SATURATE  (SATURATE)
        ) u_slice (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (evt_inc_i[i*INC_WIDTH +: INC_WIDTH]),
            .en_i  (cnt_en_i[i]),
            .clr_i (cnt_clr_i[i]),
            .rc_i  (rc_vec[i]),
            .cnt_o (live_cnt[i]),
            .ovf_o (ovf_o[i])
        );

        assign cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = live_cnt[i];
    end

`ifdef AXI_RISCV_AMO_PERF_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_cnt [NUM_CNT];
    logic [NUM_CNT-1:0]   shadow_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_cnt[i] <= '0;
            shadow_ovf <= '0;
        end else if (snap_i) begin
            for (int i = 0; i < NUM_CNT; i++) shadow_cnt[i] <= live_cnt[i];
            shadow_ovf <= ovf_o;
        end
    end

    assign src_cnt = shadow_cnt;
    assign src_ovf = shadow_ovf;
`else
    assign src_cnt = live_cnt;
    assign src_ovf = ovf_o;
`endif

    // Out-of-range indices match no entry and therefore read as zero.
    always_comb begin
        sel_data = '0;
        sel_ovf  = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_req_idx_i == IDX_WIDTH'(i)) begin
                sel_data = src_cnt[i];
                sel_ovf  = src_ovf[i];
            end
        end
    end

    always_comb begin
        rsp_d      = '0;
        rsp_d.data = MAX_CNT_WIDTH'(sel_data);
        rsp_d.ovf  = sel_ovf;
        rsp_d.err  = !idx_ok;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else if (req_accept) begin
            rsp_valid_q <= 1'b1;
            rsp_q       <= rsp_d;
        end else if (rd_rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rd_rsp_valid_o  = rsp_valid_q;
    assign rd_rsp_data_o   = rsp_q.data[CNT_WIDTH-1:0];
    assign rd_rsp_ovf_o    = rsp_q.ovf;
    assign rd_rsp_err_o    = rsp_q.err;
    assign rsp_data_unused = ^rsp_q.data;

endmodule
